// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//
// Shares one memory port between the CPU controller and a program
// loader/DMA port. The winning request is latched, the memory strobe is held
// for WAIT_CYC cycles, read data is captured into the winner's rdata
// register, and a one-cycle done pulse is returned to that requester.
//
// Handshake (both requesters): req is a level held together with
// we/addr/wdata until the matching done pulse is seen; the requester drops
// req in the cycle after done. The command is latched at grant, so anything
// the requester does to req/we/addr/wdata during ACCESS or DONE is ignored.
//
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   cpu_req/we/addr/wdata         CPU command;    cpu_rdata, cpu_done back
//   ldr_req/we/addr/wdata         loader command; ldr_rdata, ldr_done back
//   mem_addr, mem_wdata           latched command to memory
//   rd_mem, wr_mem                memory strobes (ACCESS only)
//   mem_rdata                     memory read data
//   busy                          high in ACCESS and DONE
//   grant_id                      0 = CPU, 1 = loader (valid while busy)
//   dbg_state                     FSM state (0 IDLE, 1 ACCESS, 2 DONE)
module mem_access_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int WAIT_CYC   = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          rd_mem,
  output logic          wr_mem,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id,
  output logic [1:0]    dbg_state
);

  if ((WAIT_CYC < 1) || (WAIT_CYC > 15)) begin : g_bad_wait_cyc
    $error("mem_access_arbiter: WAIT_CYC=%0d is outside 1..15", WAIT_CYC);
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // The counter holds "ACCESS cycles remaining after this one".
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          cpu_done_q, cpu_done_d;
  logic          ldr_done_q, ldr_done_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;

  // Winner selection: 1 = loader. With both requesting, round-robin hands the
  // port to whoever did not have it last.
  logic pick_ldr;
  logic cmd_we;

  always_comb begin
    if (cpu_req && ldr_req) begin
      pick_ldr = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      pick_ldr = ldr_req;
    end
    cmd_we = pick_ldr ? ldr_we : cpu_we;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    cpu_done_d   = 1'b0;
    ldr_done_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req || ldr_req) begin
          state_d      = ST_ACCESS;
          cnt_d        = CNT_INIT;
          we_d         = cmd_we;
          grant_d      = pick_ldr;
          last_grant_d = pick_ldr;
          mem_addr_d   = pick_ldr ? ldr_addr  : cpu_addr;
          mem_wdata_d  = pick_ldr ? ldr_wdata : cpu_wdata;
          rd_d         = ~cmd_we;
          wr_d         = cmd_we;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Last access cycle: strobe drops, done rises, read data lands
          // only in the granted requester's register.
          state_d = ST_DONE;
          if (grant_q) begin
            ldr_done_d = 1'b1;
          end else begin
            cpu_done_d = 1'b1;
          end
          if (!we_q) begin
            if (grant_q) begin
              ldr_rdata_d = mem_rdata;
            end else begin
              cpu_rdata_d = mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
          rd_d  = ~we_q;
          wr_d  = we_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      busy_q       <= 1'b0;
      cpu_done_q   <= 1'b0;
      ldr_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      busy_q       <= busy_d;
      cpu_done_q   <= cpu_done_d;
      ldr_done_q   <= ldr_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_done  = cpu_done_q;
  assign ldr_rdata = ldr_rdata_q;
  assign ldr_done  = ldr_done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_mem    = rd_q;
  assign wr_mem    = wr_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;
  assign dbg_state = state_q;

endmodule
